// File: rtl/terminal_sink_monitor.sv
// Sink-side observer for a single-bit routed net: synchronizes it, reports level and
// edges, counts transitions (saturating) and flags a net that has stopped toggling.
module terminal_sink_monitor #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CNT_WIDTH    = 8,
  parameter int unsigned STUCK_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 d,
  input  logic                 clear,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 stuck
);

  localparam logic [15:0] STUCK_LIMIT = 16'(STUCK_CYCLES);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   edge_det;
  logic [15:0]            timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
    end
  end

  assign level = sync[SYNC_STAGES-1];

  // Counter and timer act on the edge in the same cycle the rise/fall pulse is registered.
  assign edge_det = level ^ prev;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      prev <= level;
      rise <= level & ~prev;
      fall <= ~level & prev;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      edge_count <= '0;
      timer      <= '0;
      stuck      <= 1'b0;
    end else if (clear) begin
      edge_count <= '0;
      timer      <= '0;
      stuck      <= 1'b0;
    end else if (edge_det) begin
      if (edge_count != '1) begin
        edge_count <= edge_count + 1'b1;
      end
      timer <= '0;
      stuck <= 1'b0;
    end else begin
      stuck <= (timer == STUCK_LIMIT);
      if (timer != STUCK_LIMIT) begin
        timer <= timer + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_terminal_sink_monitor.sv
// Bench for terminal_sink_monitor: cycle model feeding a scoreboard, a segment table,
// and hand-written sequences for stuck recovery, clear/edge collision and async reset.
module tb_terminal_sink_monitor;

  localparam int unsigned STUCK = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       d     = 1'b0;
  logic       clear = 1'b0;
  logic       level, rise, fall, stuck;
  logic [7:0] edge_count;
  logic       level2, rise2, fall2, stuck2;
  logic [1:0] edge_count2;

  terminal_sink_monitor #(.SYNC_STAGES(2), .CNT_WIDTH(8), .STUCK_CYCLES(STUCK)) dut (
    .clock(clock), .reset(reset), .d(d), .clear(clear),
    .level(level), .rise(rise), .fall(fall), .edge_count(edge_count), .stuck(stuck)
  );

  terminal_sink_monitor #(.SYNC_STAGES(2), .CNT_WIDTH(2), .STUCK_CYCLES(STUCK)) dut2 (
    .clock(clock), .reset(reset), .d(d), .clear(clear),
    .level(level2), .rise(rise2), .fall(fall2), .edge_count(edge_count2), .stuck(stuck2)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       level;
    logic       rise;
    logic       fall;
    logic [7:0] cnt;
    logic       stuck;
    logic [1:0] cnt2;
  } obs_t;

  typedef struct {
    logic        d;
    logic        clr;
    int unsigned n;
    logic [7:0]  cnt;
    logic [1:0]  cnt2;
    logic        stuck;
  } vec_t;

  obs_t        sbq[$];
  vec_t        tbl[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  // Reference model: d history (index 0 newest) plus counter/timer state.
  logic [3:0]  hist;
  logic [7:0]  m_cnt;
  logic [1:0]  m_cnt2;
  int unsigned m_tm;
  logic        m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    hist   = '0;
    m_cnt  = '0;
    m_cnt2 = '0;
    m_tm   = 0;
    m_st   = 1'b0;
  endtask

  // Drive one cycle (called at a negedge), check after the posedge, return at the next negedge.
  task automatic step(input logic dv, input logic cv, input string tag);
    obs_t e;
    obs_t a;
    d     = dv;
    clear = cv;
    hist  = {hist[2:0], dv};
    e.level = hist[1];
    e.rise  = hist[2] & ~hist[3];
    e.fall  = ~hist[2] & hist[3];
    if (cv) begin
      m_cnt = '0; m_cnt2 = '0; m_tm = 0; m_st = 1'b0;
    end else if (hist[2] ^ hist[3]) begin
      if (m_cnt != 8'hff) m_cnt = m_cnt + 8'd1;
      if (m_cnt2 != 2'b11) m_cnt2 = m_cnt2 + 2'd1;
      m_tm = 0;
      m_st = 1'b0;
    end else begin
      m_st = (m_tm == STUCK);
      if (m_tm < STUCK) m_tm++;
    end
    e.cnt   = m_cnt;
    e.stuck = m_st;
    e.cnt2  = m_cnt2;
    sbq.push_back(e);
    @(posedge clock);
    #1;
    a = '{level: level, rise: rise, fall: fall, cnt: edge_count, stuck: stuck, cnt2: edge_count2};
    if (sbq.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk(tag, 32'(a), 32'(e));
      chk({tag, "_w2"}, 32'({level2, rise2, fall2, stuck2}), 32'({e.level, e.rise, e.fall, e.stuck}));
      if (rise && fall) chk({tag, "_rise_fall_both"}, 32'd1, 32'd0);
    end
    @(negedge clock);
  endtask

  task automatic toggles(input int unsigned n, input logic first, input string tag);
    logic v;
    v = first;
    for (int unsigned k = 0; k < n; k++) begin
      for (int unsigned c = 0; c < 4; c++) step(v, 1'b0, tag);
      v = ~v;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first_stuck;
    int unsigned rise_at;
    int unsigned stuck_at;
    int unsigned n_rise;
    int unsigned n_fall;
    logic        v;

    // Segment table: toggle every 4 clocks for 20 toggles, then hold low until stuck.
    v = 1'b1;
    for (int unsigned i = 1; i <= 20; i++) begin
      tbl.push_back('{d: v, clr: 1'b0, n: 4, cnt: 8'(i), cnt2: (i >= 3) ? 2'd3 : 2'(i), stuck: 1'b0});
      v = ~v;
    end
    tbl.push_back('{d: 1'b0, clr: 1'b0, n: 12, cnt: 8'd20, cnt2: 2'd3, stuck: 1'b1});

    // Reset state while reset is held.
    @(posedge clock);
    #1;
    chk("reset_state", 32'({level, rise, fall, edge_count, stuck, level2, rise2, fall2, edge_count2, stuck2}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();

    // Tied low: stuck asserts STUCK+1 clocks after release and stays.
    first_stuck = 0;
    for (int unsigned i = 1; i <= 14; i++) begin
      step(1'b0, 1'b0, "tied_low");
      if (stuck && first_stuck == 0) first_stuck = i;
    end
    chk("tied_low_stuck_cycle", 32'(first_stuck), 32'(STUCK + 1));
    chk("tied_low_stuck_held", 32'(stuck), 32'd1);

    // Table-driven toggling with end-of-segment checks.
    n_rise = 0;
    n_fall = 0;
    for (int unsigned t = 0; t < tbl.size(); t++) begin
      for (int unsigned c = 0; c < tbl[t].n; c++) begin
        step(tbl[t].d, tbl[t].clr, "toggle");
        if (rise) n_rise++;
        if (fall) n_fall++;
      end
      chk($sformatf("seg%0d_count", t), 32'(edge_count), 32'(tbl[t].cnt));
      chk($sformatf("seg%0d_count2", t), 32'(edge_count2), 32'(tbl[t].cnt2));
      chk($sformatf("seg%0d_stuck", t), 32'(stuck), 32'(tbl[t].stuck));
    end
    chk("toggle_rises", 32'(n_rise), 32'd10);
    chk("toggle_falls", 32'(n_fall), 32'd10);

    // Recovery from stuck: single rise, stuck re-asserts STUCK+1 clocks after the edge.
    rise_at  = 0;
    stuck_at = 0;
    for (int unsigned i = 1; i <= 30 && stuck_at == 0; i++) begin
      step(1'b1, 1'b0, "recover");
      if (rise && rise_at == 0) begin
        rise_at = i;
        chk("recover_stuck_drop", 32'(stuck), 32'd0);
      end else if (stuck && rise_at != 0) begin
        stuck_at = i;
      end
    end
    chk("recover_rise_seen", 32'(rise_at != 0), 32'd1);
    chk("recover_reassert_gap", 32'(stuck_at - rise_at), 32'(STUCK + 1));

    // Clear colliding with a generated fall at edge_count = 5.
    for (int unsigned c = 0; c < 4; c++) step(1'b0, 1'b0, "pre_clear");
    step(1'b0, 1'b1, "clear_idle");
    toggles(5, 1'b1, "count_to5");
    chk("pre_collision_count", 32'(edge_count), 32'd5);
    step(1'b0, 1'b0, "collide_a");
    step(1'b0, 1'b0, "collide_b");
    step(1'b0, 1'b1, "collide_c");
    chk("collision_fall", 32'(fall), 32'd1);
    chk("collision_count", 32'(edge_count), 32'd0);
    chk("collision_stuck", 32'(stuck), 32'd0);
    step(1'b0, 1'b0, "post_collision");
    chk("post_collision_count", 32'(edge_count), 32'd0);

    // Asynchronous reset mid-count with d high.
    toggles(7, 1'b1, "count_to7");
    chk("pre_reset_count", 32'(edge_count), 32'd7);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset", 32'({level, rise, fall, edge_count, stuck, level2, rise2, fall2, edge_count2, stuck2}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    n_rise = 0;
    for (int unsigned i = 0; i < 6; i++) begin
      step(1'b1, 1'b0, "after_reset");
      if (rise) n_rise++;
    end
    chk("after_reset_rises", 32'(n_rise), 32'd1);
    chk("after_reset_count", 32'(edge_count), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
